// File: rtl/wb_ddr_arbiter_if.sv
// wb_ddr_arbiter_if: one Wishbone link; the master modport drives the request side, the slave modport answers it
interface wb_ddr_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  modport master(output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
  modport slave(input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_ddr_arbiter.sv
// wb_ddr_arbiter: two-master round-robin Wishbone arbiter with cycle-held grant and stall timeout
module wb_ddr_arbiter #(
  parameter int timeout_width = 10,
  parameter bit last_reset    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  wb_ddr_arbiter_if.slave   m0,
  wb_ddr_arbiter_if.slave   m1,
  wb_ddr_arbiter_if.master  s,
  output logic [1:0]        grant_o
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_d;
  logic last, last_d;
  logic [timeout_width-1:0] cnt, cnt_d;
  logic g0, g1, cyc_x, stb_x, fire;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= last_reset;
      cnt   <= '0;
    end else begin
      state <= state_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end
  assign g0 = state == G0;
  assign g1 = state == G1;
  assign grant_o = {g1, g0};
  assign cyc_x = g0 ? m0.cyc : g1 ? m1.cyc : 1'b0;
  assign stb_x = g0 ? m0.stb : g1 ? m1.stb : 1'b0;
  // Timeout only fires on a genuinely stalled beat, never alongside a slave response
  assign fire = cyc_x & stb_x & (cnt == '1) & ~s.ack & ~s.err;
  assign s.adr   = g0 ? m0.adr   : g1 ? m1.adr   : '0;
  assign s.dat_w = g0 ? m0.dat_w : g1 ? m1.dat_w : '0;
  assign s.sel   = g0 ? m0.sel   : g1 ? m1.sel   : '0;
  assign s.we    = g0 ? m0.we    : g1 ? m1.we    : 1'b0;
  assign s.cyc   = cyc_x & ~fire;
  assign s.stb   = stb_x & ~fire;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack = g0 & s.ack;
  assign m1.ack = g1 & s.ack;
  assign m0.err = g0 & (s.err | fire);
  assign m1.err = g1 & (s.err | fire);
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = (m0.cyc & m1.cyc) ? (last ? G0 : G1) : m0.cyc ? G0 : m1.cyc ? G1 : IDLE;
      G0:      state_d = m0.cyc ? G0 : m1.cyc ? G1 : IDLE;
      G1:      state_d = m1.cyc ? G1 : m0.cyc ? G0 : IDLE;
      default: state_d = IDLE;
    endcase
    last_d = (g0 & ~m0.cyc) ? 1'b0 : (g1 & ~m1.cyc) ? 1'b1 : last;
    // s.cyc/s.stb are low on release, timeout and idle, so this also clears on those
    cnt_d = (s.cyc & s.stb & ~s.ack & ~s.err) ? cnt + 1'b1 : '0;
  end
endmodule
